// File: rtl/frequency_meter.sv
// Gated edge counter: counts synchronized rising edges of SigIn over GATE_CYCLES
// clock cycles and publishes the count once per contiguous window.
module frequency_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int          CNT_W       = 32
) (
    input  logic             CLKIn,
    input  logic             Reset,
    input  logic             SigIn,
    input  logic             Enable,
    output logic [CNT_W-1:0] Freq,
    output logic             Valid,
    output logic             Overflow,
    output logic             Busy
);

    typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

    localparam logic [31:0]      LAST_GATE = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [31:0]      gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             win_ovf_q, win_ovf_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic             edge_det, at_max, last_gate, ovf_next;
    logic [CNT_W-1:0] cnt_next;

    // sync_q[0..2] = s1..s3; s1/s2 form the synchronizer, s3 the edge reference
    assign sync_d    = {sync_q[1:0], SigIn};
    assign edge_det  = sync_q[1] & ~sync_q[2];
    assign at_max    = (edge_cnt_q == CNT_MAX);
    assign last_gate = (gate_cnt_q == LAST_GATE);
    assign cnt_next  = (edge_det && !at_max) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign ovf_next  = win_ovf_q | (edge_det & at_max);

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        win_ovf_d  = win_ovf_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                win_ovf_d  = 1'b0;
                if (Enable) state_d = ARM;
            end
            ARM: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                win_ovf_d  = 1'b0;
                state_d    = Enable ? GATE : IDLE;
            end
            GATE: begin
                if (last_gate) begin
                    // closing cycle: its own edge belongs to this window
                    freq_d     = cnt_next;
                    ovf_d      = ovf_next;
                    valid_d    = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    win_ovf_d  = 1'b0;
                    state_d    = Enable ? GATE : IDLE;
                end else if (!Enable) begin
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    win_ovf_d  = 1'b0;
                    state_d    = IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + 32'd1;
                    edge_cnt_d = cnt_next;
                    win_ovf_d  = ovf_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKIn) begin
        if (Reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            win_ovf_q  <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            win_ovf_q  <= win_ovf_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign Freq     = freq_q;
    assign Overflow = ovf_q;
    assign Valid    = valid_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter with a 100-cycle gate: a 32-bit counter
// instance for timing/counting and a 4-bit instance for saturation.
module tb_frequency_meter;

    logic        CLKIn = 1'b0;
    logic        Reset, SigIn, Enable, Enable2;
    logic [31:0] freq;
    logic        valid, ovf, busy;
    logic [3:0]  freq2;
    logic        valid2, ovf2, busy2;

    int errors = 0;
    int checks = 0;
    int per    = 0;
    int phase  = 0;

    frequency_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut (
        .CLKIn(CLKIn), .Reset(Reset), .SigIn(SigIn), .Enable(Enable),
        .Freq(freq), .Valid(valid), .Overflow(ovf), .Busy(busy)
    );

    frequency_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .CLKIn(CLKIn), .Reset(Reset), .SigIn(SigIn), .Enable(Enable2),
        .Freq(freq2), .Valid(valid2), .Overflow(ovf2), .Busy(busy2)
    );

    always #10 CLKIn = ~CLKIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one cycle; outputs are stable at the falling edge, then SigIn advances
    task automatic step();
        @(negedge CLKIn);
        if (per != 0) begin
            phase = (phase + 1) % per;
            SigIn = (phase < per / 2);
        end
    endtask

    task automatic wait_valid(input bit which, input int max, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < max) begin
            step();
            i++;
            if ((which ? valid2 : valid) === 1'b1) n = i;
        end
    endtask

    initial begin
        int n;
        int extra;
        Reset = 1'b1; Enable = 1'b0; Enable2 = 1'b0; SigIn = 1'b0; per = 10;

        // reset state
        repeat (3) step();
        chk("rst_freq", freq, 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        Reset = 1'b0;
        repeat (5) step();
        chk("idle_busy", 32'(busy), 0);

        // period 10, continuous: 1 ARM + 100 GATE, Valid in the 102nd cycle
        Enable = 1'b1;
        wait_valid(0, 200, n);
        chk("first_latency", n, 102);
        chk("p10_freq", freq, 10);
        chk("p10_ovf", 32'(ovf), 0);
        step();
        chk("valid_width", 32'(valid), 0);
        wait_valid(0, 200, n);
        chk("valid_spacing", n, 99);
        chk("p10_freq2", freq, 10);

        // abort at gate count 50
        repeat (50) step();
        chk("abort_busy_before", 32'(busy), 1);
        Enable = 1'b0;
        step();
        chk("abort_busy_after", 32'(busy), 0);
        wait_valid(0, 150, n);
        chk("abort_no_valid", n, -1);
        chk("abort_freq_kept", freq, 10);
        chk("abort_ovf_kept", 32'(ovf), 0);

        // SigIn rises one cycle before Enable and stays high: no false edge
        per = 0; SigIn = 1'b0;
        repeat (5) step();
        SigIn = 1'b1;
        step();
        Enable = 1'b1;
        wait_valid(0, 200, n);
        chk("high_latency", n, 102);
        chk("high_freq", freq, 0);

        // 9 early pulses plus one edge landing on the last gate cycle
        extra = 0;
        for (int t = 1; t <= 99; t++) begin
            step();
            SigIn = ((t >= 10 && t <= 94 && (t % 10) < 5) || t >= 97);
            if (valid === 1'b1) extra++;
        end
        step();
        chk("boundary_no_early_valid", extra, 0);
        chk("boundary_valid", 32'(valid), 1);
        chk("boundary_freq", freq, 10);
        repeat (99) step();
        step();
        chk("after_boundary_valid", 32'(valid), 1);
        chk("after_boundary_freq", freq, 0);

        // reset mid-window while enabled and toggling
        per = 10; phase = 0;
        wait_valid(0, 200, n);
        wait_valid(0, 200, n);
        chk("pre_reset_freq", freq, 10);
        repeat (30) step();
        Reset = 1'b1;
        repeat (3) step();
        chk("midrst_freq", freq, 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_ovf", 32'(ovf), 0);
        chk("midrst_busy", 32'(busy), 0);
        phase = 5; SigIn = 1'b0; Reset = 1'b0;
        wait_valid(0, 200, n);
        chk("postrst_latency", n, 102);
        chk("postrst_freq", freq, 10);

        // saturation on the 4-bit instance: 50 edges -> 15 with overflow
        Enable = 1'b0;
        per = 2; phase = 0;
        Enable2 = 1'b1;
        wait_valid(1, 200, n);
        chk("sat_latency", n, 102);
        chk("sat_freq", freq2, 15);
        chk("sat_ovf", 32'(ovf2), 1);
        per = 10;
        wait_valid(1, 200, n);
        wait_valid(1, 200, n);
        chk("unsat_found", 32'(n > 0), 1);
        chk("unsat_freq", freq2, 10);
        chk("unsat_ovf", 32'(ovf2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
